// File: rtl/life_pkg.sv
// Shared definitions for the life arena cell access blocks.
package life_pkg;

  // Width of cell coordinates, shared with cell_reader.
  localparam int CELL_COORD_W = 8;

  // Writer FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/cell_writer_if.sv
// Request side of the cell writer: start/ready handshake plus the target cell.
//
// Handshake: a request is accepted on a rising clk edge where start=1 and
// ready=1; cell_column/cell_row/cell_value are sampled on that edge only.
// start while ready=0 is ignored, never queued. Completion is signalled by a
// one-cycle done pulse; error pulses with done when the request was dropped
// for being outside the arena.
interface cell_writer_if
  import life_pkg::*;
();

  logic                    start;
  logic                    ready;
  logic                    done;
  logic                    error;
  logic [CELL_COORD_W-1:0] cell_column;
  logic [CELL_COORD_W-1:0] cell_row;
  logic                    cell_value;

  // Requester: next-generation update logic or the seed/edit loader.
  modport master (
    output start,
    output cell_column,
    output cell_row,
    output cell_value,
    input  ready,
    input  done,
    input  error
  );

  // The cell writer itself.
  modport slave (
    input  start,
    input  cell_column,
    input  cell_row,
    input  cell_value,
    output ready,
    output done,
    output error
  );

endinterface

// File: rtl/cell_writer.sv
// Read-modify-write of a single cell in the life arena: select the row, capture
// it with one bit replaced, then write the whole row back.
module cell_writer
  import life_pkg::*;
#(
  parameter int ARENA_WIDTH  = 10,
  parameter int ARENA_HEIGHT = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  cell_writer_if.slave            req,
  output logic [CELL_COORD_W-1:0] arena_row_select,
  input  logic [ARENA_WIDTH-1:0]  arena_columns,
  output logic [ARENA_WIDTH-1:0]  arena_columns_out,
  output logic                    arena_write_enable,
  output state_t                  fsm_state
);

  state_t                  state;
  state_t                  state_next;
  logic [CELL_COORD_W-1:0] col_q;
  logic [CELL_COORD_W-1:0] row_q;
  logic                    val_q;
  logic                    drop_q;
  logic [ARENA_WIDTH-1:0]  row_word_q;
  logic [ARENA_WIDTH-1:0]  row_mod;
  logic                    accept;
  logic                    in_range;

  assign fsm_state = state;
  assign accept    = (state == ST_IDLE) && req.start;
  assign in_range  = (32'(req.cell_column) < 32'(ARENA_WIDTH)) &&
                     (32'(req.cell_row) < 32'(ARENA_HEIGHT));

  // Captured row with the target column replaced by the latched value.
  always_comb begin
    row_mod = arena_columns;
    for (int i = 0; i < ARENA_WIDTH; i++) begin
      if (col_q == CELL_COORD_W'(i)) row_mod[i] = val_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Request capture, drop flag and the modified row word.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      val_q      <= 1'b0;
      drop_q     <= 1'b0;
      row_word_q <= '0;
    end else begin
      // Only an accepted start may touch the latched request.
      if (accept) begin
        col_q <= req.cell_column;
        row_q <= req.cell_row;
        val_q <= req.cell_value;
      end
      drop_q <= accept && !in_range;
      if (state == ST_READ) row_word_q <= row_mod;
    end
  end

  // Next state and outputs. Reset gates the write enable combinationally so
  // a WRITE cycle that coincides with reset never reaches the arena.
  always_comb begin
    state_next         = state;
    req.ready          = 1'b0;
    arena_row_select   = '0;
    arena_write_enable = 1'b0;
    case (state)
      ST_IDLE: begin
        req.ready = 1'b1;
        if (req.start && in_range) state_next = ST_READ;
      end
      ST_READ: begin
        arena_row_select = row_q;
        state_next       = ST_WRITE;
      end
      ST_WRITE: begin
        arena_row_select   = row_q;
        arena_write_enable = !reset;
        state_next         = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    req.error         = drop_q && !reset;
    req.done          = req.error || arena_write_enable;
    arena_columns_out = arena_write_enable ? row_word_q : '0;
  end

endmodule
